// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first,
// with valid/ready operand intake and valid/ready result delivery.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; ready/valid outputs are decoded from registered state only.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             fa_s, fa_c;

   full_adder u_fa (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            carry_d = fa_c;
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // Last bit: capture the final carry and leave before the counter wraps.
            if (cnt_q == CW'(WIDTH - 1)) begin
               cout_d  = fa_c;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the main scenarios
// and a 2-bit instance for the exhaustive truth-table sweep.

module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [7:0] a, b, sum;
   logic [1:0] dbg_state;

   logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
   logic [1:0] a2, b2, sum2;
   logic [1:0] dbg_state2;

   int checks   = 0;
   int failures = 0;
   int cycle_cnt = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   serial_adder_ctrl #(.WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy), .dbg_state_o(dbg_state)
   );

   serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .busy(busy2), .dbg_state_o(dbg_state2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction on the 8-bit instance with out_ready held high.
   task automatic do_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic [8:0] exp, input string tag);
      int n;
      check({tag, "_in_ready"}, in_ready, 1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, 8);
      check({tag, "_result"}, {cout, sum}, exp);
      tick();
      check({tag, "_idle_after"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   task automatic do_add2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
      int n;
      logic [2:0] exp;
      exp = 3'(ta) + 3'(tb) + 3'(tc);
      a2 = ta; b2 = tb; cin2 = tc; in_valid2 = 1'b1; out_ready2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 10) begin
         tick();
         n++;
      end
      check($sformatf("w2_%0d_%0d_%0d", ta, tb, tc), {n[3:0], cout2, sum2}, {4'd2, exp});
      tick();
   endtask

   initial begin
      int idx, got, last_acc;
      logic [7:0] pa[4];
      logic [7:0] pb[4];
      logic [8:0] hold;

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_ctrl", {in_ready, out_valid, busy, dbg_state}, 5'b10000);
      check("reset_data", {cout, sum}, 9'h000);
      check("reset_w2", {in_ready2, out_valid2, busy2}, 3'b100);

      // Basic sums and carry boundaries.
      do_add(8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c");
      do_add(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
      do_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, "add_ff_ff_c");
      do_add(8'h00, 8'h00, 1'b1, 9'h001, "add_00_00_c");

      // Backpressure: result held while out_ready is low, new operands ignored.
      a = 8'h80; b = 8'h81; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      hold = 9'h101;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold_%0d", i), {out_valid, in_ready, busy, cout, sum}, {3'b101, hold});
         in_valid = ~in_valid;
         a = 8'($urandom); b = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_still_done", {out_valid, cout, sum}, {1'b1, hold});
      tick();
      check("bp_release", {in_ready, out_valid, busy}, 3'b100);
      tick();
      check("bp_no_ghost", {in_ready, busy}, 2'b10);

      // Reset on the 4th RUN edge discards the in-flight add.
      a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      check("rst_midrun_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_midrun_state", {in_ready, out_valid, busy, cout, sum}, {3'b100, 9'h000});
      do_add(8'h01, 8'h02, 1'b0, 9'h003, "after_rst");

      // Back-to-back with in_valid held high; one accept every 10 cycles.
      pa[0] = 8'h11; pb[0] = 8'h22;
      pa[1] = 8'hF0; pb[1] = 8'h20;
      pa[2] = 8'h7F; pb[2] = 8'h01;
      pa[3] = 8'hAA; pb[3] = 8'h55;
      in_valid = 1'b1; out_ready = 1'b1; cin = 1'b0;
      idx = 0; got = 0; last_acc = 0;
      for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
         if (idx == 4 && !in_ready) in_valid = 1'b0;
         if (in_ready && idx < 4) begin
            a = pa[idx]; b = pb[idx];
            exp_q.push_back({1'b0, pa[idx]} + {1'b0, pb[idx]});
            if (idx > 0) check($sformatf("b2b_period_%0d", idx), cycle_cnt - last_acc, 10);
            last_acc = cycle_cnt;
            idx++;
         end
         if (out_valid) begin
            if (exp_q.size() > 0) check($sformatf("b2b_sum_%0d", got), {cout, sum}, exp_q.pop_front());
            got++;
         end
         tick();
      end
      in_valid = 1'b0;
      check("b2b_count", got, 4);
      check("b2b_hand_vals", {pa[1] + pb[1]}, 8'h10);

      // Exhaustive sweep of the 2-bit instance.
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 2; k++)
               do_add2(2'(i), 2'(j), 1'(k));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
